// File: rtl/instr_execute_pkg.sv
// Shared types for the RV32I execute stage: ALU opcodes, branch conditions,
// stage FSM states and the decoded-instruction / execute-result records.
// Also carries the branch-compare helper shared by anything that resolves branches.
package instr_execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } br_cond_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REDIR   = 2'd1,
        TRAPPED = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        use_imm;
        alu_op_t     op;
        logic        is_branch;
        br_cond_t    br_cond;
        logic        is_jal;
        logic        is_jalr;
        logic        is_mem;
        logic        illegal;
    } decoded_instr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] addr;
        logic        wen;
        logic        is_mem;
        logic        exc;
    } ex_result_t;

    localparam int DECODED_W = $bits(decoded_instr_t);
    localparam int RESULT_W  = $bits(ex_result_t);

    // Branch condition evaluation; unknown condition codes never take.
    function automatic logic br_taken(input br_cond_t c, input logic [31:0] a,
                                      input logic [31:0] b);
        case (c)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_execute_alu.sv
// Purpose: 32-bit RV32I integer ALU, wrap-around arithmetic, no overflow flags.
// Latency: purely combinational (op, a, b) -> y.
// Backpressure: none; ports: op (alu_op_t encoding), a, b operands, y result.
module instr_execute_alu
    import instr_execute_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    alu_op_t    op_e;
    logic [4:0] shamt;

    assign op_e  = alu_op_t'(op);
    assign shamt = b[4:0];

    always_comb begin
        y = 32'h0;
        case (op_e)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {31'h0, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_LUI:   y = b;
            // Caller presents pc on a for AUIPC.
            ALU_AUIPC: y = a + b;
            default:   y = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_execute.sv
// Purpose: RV32I execute stage: ALU, branch/jump resolution, fetch redirect, trap hold.
// Latency: exactly 1 cycle from decoded accept to registered result; redirect pulses with it.
// Backpressure: decoded_ready = !result_valid || result_ready in RUN, 0 in REDIR/TRAPPED or on flush.
// Ports: clk/rst (async, active-high); decoded_valid/_ready/_data (decoded_instr_t bits) in;
//        result_valid/_ready/_data (ex_result_t bits) out; redirect_valid/redirect_pc; flush in.
module instr_execute
    import instr_execute_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 decoded_valid,
    output logic                 decoded_ready,
    input  logic [DECODED_W-1:0] decoded_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [RESULT_W-1:0]  result_data,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 flush
);

    decoded_instr_t din;
    assign din = decoded_instr_t'(decoded_data);

    exec_state_t state_q, state_d;
    logic        result_valid_q, result_valid_d;
    ex_result_t  result_data_q, result_data_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] op_a, op_b, alu_y;
    logic [31:0] rs1_imm, target;
    logic        is_jump, taken, misaligned, exc, do_redirect, accept;
    ex_result_t  res;

    // LUI/AUIPC always take imm as their second operand regardless of use_imm.
    always_comb begin
        op_a = (din.op == ALU_AUIPC) ? din.pc : din.rs1_val;
        op_b = (din.use_imm || din.op == ALU_LUI || din.op == ALU_AUIPC) ? din.imm : din.rs2_val;
    end

    instr_execute_alu u_alu (
        .op (din.op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    // Control-flow resolution. rs1+imm doubles as the JALR base and the LSU address.
    always_comb begin
        rs1_imm     = din.rs1_val + din.imm;
        is_jump     = din.is_jal || din.is_jalr;
        taken       = is_jump ||
                      (din.is_branch && br_taken(din.br_cond, din.rs1_val, din.rs2_val));
        target      = din.is_jalr ? {rs1_imm[31:1], 1'b0} : din.pc + din.imm;
        misaligned  = ALIGN_CHECK && taken && target[1];
        exc         = din.illegal || misaligned;
        do_redirect = taken && !exc;
    end

    always_comb begin
        res        = '0;
        res.pc     = din.pc;
        res.rd     = din.rd;
        res.is_mem = din.is_mem;
        res.exc    = exc;
        if (din.is_mem) begin
            res.value = din.rs2_val;
            res.addr  = rs1_imm;
        end else if (is_jump) begin
            res.value = din.pc + 32'd4;
        end else if (!din.is_branch) begin
            res.value = alu_y;
        end
        // Branches write nothing; the LSU owns memory-op writeback; x0 is never written.
        res.wen = !exc && !din.is_mem && (is_jump || !din.is_branch) && (din.rd != 5'd0);
    end

    always_comb begin
        state_d          = state_q;
        result_valid_d   = result_valid_q;
        result_data_d    = result_data_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'h0;
        decoded_ready    = 1'b0;

        case (state_q)
            RUN:     decoded_ready = !result_valid_q || result_ready;
            // One bubble after a redirect: the next offered instruction is wrong-path.
            REDIR:   state_d = RUN;
            TRAPPED: decoded_ready = 1'b0;
            default: state_d = RUN;
        endcase

        if (flush) begin
            decoded_ready = 1'b0;
        end
        accept = decoded_valid && decoded_ready;

        if (result_valid_q && result_ready) begin
            result_valid_d = 1'b0;
        end

        if (accept) begin
            result_valid_d = 1'b1;
            result_data_d  = res;
            if (exc) begin
                state_d = TRAPPED;
            end else if (do_redirect) begin
                state_d          = REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target;
            end
        end

        if (flush) begin
            result_valid_d = 1'b0;
            state_d        = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            result_valid_q   <= 1'b0;
            result_data_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            result_valid_q   <= result_valid_d;
            result_data_q    <= result_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign result_valid   = result_valid_q;
    assign result_data    = result_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_instr_execute.sv
// Bench for instr_execute: directed scenarios plus a randomized stream checked
// against a transaction-level reference model and an in-order result queue.
module tb_instr_execute;
    import instr_execute_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 decoded_valid;
    logic                 decoded_ready;
    logic [DECODED_W-1:0] decoded_data;
    logic                 result_valid;
    logic                 result_ready;
    logic [RESULT_W-1:0]  result_data;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 flush;

    decoded_instr_t din;
    ex_result_t     rout;
    int passed = 0;
    int total  = 0;

    assign decoded_data = din;
    assign rout         = ex_result_t'(result_data);

    always #5 clk = ~clk;

    instr_execute #(.ALIGN_CHECK(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .decoded_valid  (decoded_valid),
        .decoded_ready  (decoded_ready),
        .decoded_data   (decoded_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_data    (result_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    // Reference model: architectural meaning of one instruction.
    function automatic ex_result_t ref_model(input decoded_instr_t d, output logic redir,
                                             output logic [31:0] tgt);
        ex_result_t  r;
        logic [31:0] a, b, v;
        logic [4:0]  sh;
        logic        cond, taken, jump, bad;
        a  = d.rs1_val;
        b  = d.use_imm ? d.imm : d.rs2_val;
        sh = b[4:0];
        case (d.op)
            ALU_ADD:   v = a + b;
            ALU_SUB:   v = a - b;
            ALU_SLL:   v = a << sh;
            ALU_SLT:   v = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            ALU_SLTU:  v = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   v = a ^ b;
            ALU_SRL:   v = a >> sh;
            ALU_SRA:   v = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            ALU_OR:    v = a | b;
            ALU_AND:   v = a & b;
            ALU_LUI:   v = d.imm;
            ALU_AUIPC: v = d.pc + d.imm;
            default:   v = 32'h0;
        endcase
        case (d.br_cond)
            BR_EQ:   cond = d.rs1_val == d.rs2_val;
            BR_NE:   cond = d.rs1_val != d.rs2_val;
            BR_LT:   cond = (d.rs1_val ^ 32'h80000000) < (d.rs2_val ^ 32'h80000000);
            BR_GE:   cond = !((d.rs1_val ^ 32'h80000000) < (d.rs2_val ^ 32'h80000000));
            BR_LTU:  cond = d.rs1_val < d.rs2_val;
            BR_GEU:  cond = !(d.rs1_val < d.rs2_val);
            default: cond = 1'b0;
        endcase
        jump  = d.is_jal || d.is_jalr;
        taken = jump || (d.is_branch && cond);
        tgt   = d.is_jalr ? ((d.rs1_val + d.imm) & 32'hFFFFFFFE) : d.pc + d.imm;
        bad   = d.illegal || (taken && tgt[1]);
        redir = taken && !bad;
        r        = '0;
        r.pc     = d.pc;
        r.rd     = d.rd;
        r.is_mem = d.is_mem;
        r.exc    = bad;
        r.value  = d.is_mem ? d.rs2_val : jump ? d.pc + 32'd4 : d.is_branch ? 32'h0 : v;
        r.addr   = d.is_mem ? d.rs1_val + d.imm : 32'h0;
        r.wen    = !bad && !d.is_mem && !d.is_branch && (d.rd != 5'd0);
        return r;
    endfunction

    // Random legal instruction; control-flow targets are kept 4-byte aligned.
    function automatic decoded_instr_t rand_instr();
        decoded_instr_t d;
        int k;
        d         = '0;
        d.pc      = $urandom & 32'hFFFFFFFC;
        d.rd      = 5'($urandom_range(0, 31));
        d.rs1_val = $urandom;
        d.rs2_val = ($urandom_range(0, 3) == 0) ? d.rs1_val : $urandom;
        d.imm     = $urandom;
        d.use_imm = 1'($urandom_range(0, 1));
        d.op      = alu_op_t'(4'($urandom_range(0, 11)));
        k         = $urandom_range(0, 9);
        if (k == 6) begin
            d.is_branch = 1'b1;
            d.br_cond   = br_cond_t'(3'($urandom_range(0, 5)));
            d.imm       = d.imm & 32'hFFFFFFFC;
        end else if (k == 7) begin
            d.is_jal = 1'b1;
            d.imm    = d.imm & 32'hFFFFFFFC;
        end else if (k == 8) begin
            d.is_jalr   = 1'b1;
            d.imm       = d.imm & 32'hFFFFFFFC;
            d.rs1_val   = d.rs1_val & 32'hFFFFFFFD;
        end else if (k == 9) begin
            d.is_mem = 1'b1;
        end
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        decoded_valid = 1'b0;
        flush         = 1'b0;
        result_ready  = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; decoded_valid = 1'b0; result_ready = 1'b1; flush = 1'b0; din = '0;
        #3;
        total++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid); else passed++;
        total++; if (result_data !== '0) $display("FAIL reset_data: got %h want 0", result_data); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL reset_redir: got %b want 0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redir_pc: got %h want 0", redirect_pc); else passed++;
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (decoded_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", decoded_ready); else passed++;
    endtask

    task automatic test_add();
        step();
        din = '0; din.op = ALU_ADD; din.rd = 5'd1; din.rs1_val = 32'd7; din.rs2_val = 32'd5;
        din.pc = 32'h100; decoded_valid = 1'b1; result_ready = 1'b1;
        #1;
        total++; if (decoded_ready !== 1'b1) $display("FAIL add_ready: got %b want 1", decoded_ready); else passed++;
        step();
        decoded_valid = 1'b0;
        total++; if (result_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", result_valid); else passed++;
        total++; if (rout.value !== 32'd12 || rout.rd !== 5'd1 || rout.wen !== 1'b1)
            $display("FAIL add_result: got value=%0d rd=%0d wen=%b want 12/1/1", rout.value, rout.rd, rout.wen);
        else passed++;
        // Back-to-back: one accept and one result every cycle.
        for (int i = 0; i < 5; i++) begin
            din = '0; din.op = ALU_ADD; din.rd = 5'd2; din.rs1_val = 32'(i); din.rs2_val = 32'd100;
            decoded_valid = 1'b1;
            step();
            total++; if (result_valid !== 1'b1 || rout.value !== 32'(i + 100))
                $display("FAIL b2b_%0d: got valid=%b value=%0d want 1/%0d", i, result_valid, rout.value, i + 100);
            else passed++;
        end
        settle();
    endtask

    task automatic test_alu_edges();
        decoded_instr_t v[4];
        logic [31:0]    ev[4];
        for (int i = 0; i < 4; i++) v[i] = '0;
        v[0].op = ALU_SRA;  v[0].rd = 5'd5; v[0].rs1_val = 32'h80000000; v[0].imm = 32'd33; v[0].use_imm = 1'b1;
        v[1].op = ALU_SLTU; v[1].rd = 5'd6; v[1].rs1_val = 32'hFFFFFFFF; v[1].rs2_val = 32'd1;
        v[2].op = ALU_SLT;  v[2].rd = 5'd7; v[2].rs1_val = 32'hFFFFFFFF; v[2].rs2_val = 32'd1;
        v[3].op = ALU_ADD;  v[3].rd = 5'd0; v[3].rs1_val = 32'd1;        v[3].rs2_val = 32'd1;
        ev[0] = 32'hC0000000; ev[1] = 32'd0; ev[2] = 32'd1; ev[3] = 32'd2;
        step();
        for (int i = 0; i < 4; i++) begin
            din = v[i]; decoded_valid = 1'b1;
            step();
            total++; if (result_valid !== 1'b1 || rout.value !== ev[i] || rout.wen !== (i != 3))
                $display("FAIL alu_edge_%0d: got valid=%b value=%h wen=%b want 1/%h/%b",
                         i, result_valid, rout.value, rout.wen, ev[i], i != 3);
            else passed++;
        end
        settle();
    endtask

    task automatic test_mem();
        step();
        din = '0; din.is_mem = 1'b1; din.rd = 5'd3; din.pc = 32'h400; din.rs1_val = 32'h1000;
        din.imm = 32'h24; din.rs2_val = 32'hDEADBEEF; decoded_valid = 1'b1;
        step();
        decoded_valid = 1'b0;
        total++; if (rout.addr !== 32'h1024 || rout.value !== 32'hDEADBEEF || rout.wen !== 1'b0 ||
                     rout.is_mem !== 1'b1 || rout.pc !== 32'h400 || rout.rd !== 5'd3)
            $display("FAIL mem_pass: got addr=%h value=%h wen=%b is_mem=%b want 1024/deadbeef/0/1",
                     rout.addr, rout.value, rout.wen, rout.is_mem);
        else passed++;
        settle();
    endtask

    task automatic test_branch();
        step();
        din = '0; din.is_branch = 1'b1; din.br_cond = BR_EQ; din.pc = 32'h80000010; din.imm = 32'h20;
        din.rs1_val = 32'd3; din.rs2_val = 32'd3; din.rd = 5'd5; decoded_valid = 1'b1; result_ready = 1'b1;
        step();
        // Wrong-path instruction stays offered during the redirect cycle.
        din = '0; din.op = ALU_ADD; din.rd = 5'd9;
        #1;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000030)
            $display("FAIL beq_redirect: got %b/%h want 1/80000030", redirect_valid, redirect_pc);
        else passed++;
        total++; if (decoded_ready !== 1'b0) $display("FAIL beq_ready_redir: got %b want 0", decoded_ready); else passed++;
        total++; if (result_valid !== 1'b1 || rout.wen !== 1'b0)
            $display("FAIL beq_result: got valid=%b wen=%b want 1/0", result_valid, rout.wen);
        else passed++;
        step();
        decoded_valid = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL beq_after: got redir=%b valid=%b want 0/0", redirect_valid, result_valid);
        else passed++;
        total++; if (decoded_ready !== 1'b1) $display("FAIL beq_ready_run: got %b want 1", decoded_ready); else passed++;
        settle();
    endtask

    task automatic test_jalr();
        step();
        din = '0; din.is_jalr = 1'b1; din.rd = 5'd1; din.pc = 32'h200; din.rs1_val = 32'h80001001;
        decoded_valid = 1'b1; result_ready = 1'b1;
        step();
        decoded_valid = 1'b0;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80001000)
            $display("FAIL jalr_redirect: got %b/%h want 1/80001000", redirect_valid, redirect_pc);
        else passed++;
        total++; if (rout.value !== 32'h204 || rout.wen !== 1'b1 || rout.exc !== 1'b0)
            $display("FAIL jalr_link: got value=%h wen=%b exc=%b want 204/1/0", rout.value, rout.wen, rout.exc);
        else passed++;
        settle();
        din.rs1_val = 32'h80001003; decoded_valid = 1'b1;
        step();
        din = '0; din.op = ALU_ADD; din.rd = 5'd4;
        #1;
        total++; if (rout.exc !== 1'b1 || rout.wen !== 1'b0 || redirect_valid !== 1'b0)
            $display("FAIL jalr_misalign: got exc=%b wen=%b redir=%b want 1/0/0", rout.exc, rout.wen, redirect_valid);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (decoded_ready !== 1'b0) $display("FAIL trap_ready_%0d: got %b want 0", i, decoded_ready); else passed++;
            step();
            #1;
        end
        flush = 1'b1;
        #1;
        total++; if (decoded_ready !== 1'b0) $display("FAIL trap_flush_ready: got %b want 0", decoded_ready); else passed++;
        step();
        flush = 1'b0;
        #1;
        total++; if (decoded_ready !== 1'b1 || result_valid !== 1'b0)
            $display("FAIL trap_release: got ready=%b valid=%b want 1/0", decoded_ready, result_valid);
        else passed++;
        decoded_valid = 1'b0;
        settle();
    endtask

    task automatic test_backpressure();
        decoded_instr_t a, b;
        ex_result_t     ea, eb;
        logic           r;
        logic [31:0]    t;
        step();
        a = '0; a.op = ALU_XOR; a.rd = 5'd2; a.rs1_val = 32'hF0F0F0F0; a.rs2_val = 32'h0FF00FF0; a.pc = 32'h40;
        b = '0; b.op = ALU_SUB; b.rd = 5'd3; b.rs1_val = 32'd10; b.rs2_val = 32'd20; b.pc = 32'h44;
        ea = ref_model(a, r, t);
        eb = ref_model(b, r, t);
        din = a; decoded_valid = 1'b1; result_ready = 1'b1;
        step();
        din = b; result_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (result_valid !== 1'b1 || result_data !== ea)
                $display("FAIL bp_hold_%0d: got %b/%h want 1/%h", i, result_valid, result_data, ea);
            else passed++;
            total++; if (decoded_ready !== 1'b0) $display("FAIL bp_ready_%0d: got %b want 0", i, decoded_ready); else passed++;
            step();
        end
        result_ready = 1'b1;
        #1;
        total++; if (decoded_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", decoded_ready); else passed++;
        step();
        decoded_valid = 1'b0;
        total++; if (result_valid !== 1'b1 || result_data !== eb)
            $display("FAIL bp_next: got %b/%h want 1/%h", result_valid, result_data, eb);
        else passed++;
        settle();
    endtask

    task automatic test_flush();
        step();
        din = '0; din.is_branch = 1'b1; din.br_cond = BR_NE; din.pc = 32'h80000100; din.imm = 32'h40;
        din.rs1_val = 32'd9; din.rs2_val = 32'd8; decoded_valid = 1'b1; result_ready = 1'b0;
        step();
        din = '0; din.op = ALU_ADD; din.rd = 5'd6; flush = 1'b1;
        #1;
        total++; if (result_valid !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h80000140)
            $display("FAIL flush_pre: got valid=%b redir=%b pc=%h want 1/1/80000140", result_valid, redirect_valid, redirect_pc);
        else passed++;
        total++; if (decoded_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", decoded_ready); else passed++;
        step();
        flush = 1'b0; decoded_valid = 1'b0;
        #1;
        total++; if (result_valid !== 1'b0 || redirect_valid !== 1'b0 || decoded_ready !== 1'b1)
            $display("FAIL flush_post: got valid=%b redir=%b ready=%b want 0/0/1", result_valid, redirect_valid, decoded_ready);
        else passed++;
        settle();
    endtask

    task automatic test_random(input int cycles);
        ex_result_t  q[$];
        ex_result_t  e;
        logic        exp_redir = 1'b0;
        logic [31:0] exp_pc = 32'h0;
        logic        pend = 1'b0;
        logic        r;
        logic [31:0] t;
        step();
        for (int c = 0; c < cycles; c++) begin
            if (!pend) begin
                din  = rand_instr();
                pend = ($urandom_range(0, 3) != 0);
            end
            decoded_valid = pend;
            result_ready  = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (result_valid !== (q.size() != 0))
                $display("FAIL rnd_valid c%0d: got %b want %b", c, result_valid, q.size() != 0);
            else passed++;
            total++; if (redirect_valid !== exp_redir || (exp_redir && redirect_pc !== exp_pc))
                $display("FAIL rnd_redirect c%0d: got %b/%h want %b/%h", c, redirect_valid, redirect_pc, exp_redir, exp_pc);
            else passed++;
            total++; if (decoded_ready !== (!exp_redir && (q.size() == 0 || result_ready)))
                $display("FAIL rnd_ready c%0d: got %b want %b", c, decoded_ready, !exp_redir && (q.size() == 0 || result_ready));
            else passed++;
            if (result_valid && result_ready && q.size() != 0) begin
                e = q.pop_front();
                total++; if (result_data !== e)
                    $display("FAIL rnd_data c%0d: got %h want %h", c, result_data, e);
                else passed++;
            end
            exp_redir = 1'b0;
            if (decoded_valid && decoded_ready) begin
                q.push_back(ref_model(din, r, t));
                exp_redir = r;
                exp_pc    = t;
                pend      = 1'b0;
            end
            step();
        end
        settle();
    endtask

    task automatic test_async_reset();
        step();
        din = '0; din.is_jal = 1'b1; din.rd = 5'd1; din.pc = 32'h1000; din.imm = 32'h80;
        decoded_valid = 1'b1; result_ready = 1'b0;
        step();
        decoded_valid = 1'b0;
        total++; if (result_valid !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1080)
            $display("FAIL arst_pre: got valid=%b redir=%b pc=%h want 1/1/1080", result_valid, redirect_valid, redirect_pc);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (result_valid !== 1'b0 || result_data !== '0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL arst_now: got valid=%b data=%h redir=%b pc=%h want all 0",
                     result_valid, result_data, redirect_valid, redirect_pc);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (decoded_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", decoded_ready); else passed++;
        settle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_edges();
        test_mem();
        test_branch();
        test_jalr();
        test_backpressure();
        test_flush();
        test_random(800);
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
